// File: rtl/cdec8_dbg_pkg.sv
// Shared definitions for the CDEC8 debug observation bus scanner:
// FSM encoding, resource address map and window sizing helper.
package cdec8_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_t;

  // Resource map of the observation bus (subset that the editor displays)
  localparam logic [7:0] RES_AD_PC_LO = 8'h00;
  localparam logic [7:0] RES_AD_PC_HI = 8'h01;
  localparam logic [7:0] RES_AD_ACC   = 8'h02;
  localparam logic [7:0] RES_AD_IR    = 8'h03;
  localparam logic [7:0] RES_AD_CTRL  = 8'h0B;
  localparam logic [7:0] RES_AD_LAST  = 8'h0F;

  localparam logic [7:0] PARK_AD_DEF  = 8'hFF;
  localparam int         SNAP_DEPTH   = 16;

  function automatic int win_size(input logic [7:0] first_ad, input logic [7:0] last_ad);
    return int'(last_ad) - int'(first_ad) + 1;
  endfunction

endpackage

// File: rtl/cdec8_res_scanner_if.sv
// Debug observation bus: scanner drives the address, addressed resource replies.
interface cdec8_res_scanner_if;
  logic [7:0] resad;
  logic [7:0] resdt;

  modport master (output resad, input resdt);
  modport slave  (input resad, output resdt);
endinterface

// File: rtl/cdec8_snap_buf.sv
// 16x8 shadow (filled per address) plus snapshot (bulk-committed) with a
// registered read port; indices at or beyond DEPTH read as zero.
module cdec8_snap_buf
  import cdec8_dbg_pkg::*;
#(
  parameter int DEPTH = SNAP_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_dt,
  input  logic       commit,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_dt
);

  logic [7:0] shadow [SNAP_DEPTH];
  logic [7:0] snap   [SNAP_DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SNAP_DEPTH; i++) begin
        shadow[i] <= 8'h00;
        snap[i]   <= 8'h00;
      end
      rd_dt <= 8'h00;
    end else begin
      if (wr_en) shadow[wr_idx] <= wr_dt;
      // Whole window moves in one edge so readers never see a mixed image
      if (commit) begin
        for (int i = 0; i < SNAP_DEPTH; i++) snap[i] <= shadow[i];
      end
      rd_dt <= ({1'b0, rd_idx} < 5'(DEPTH)) ? snap[rd_idx] : 8'h00;
    end
  end

endmodule

// File: rtl/cdec8_res_scanner.sv
// Walks the debug resource window, samples each reply after a bus settle
// time and commits the completed window to the snapshot buffer.
module cdec8_res_scanner
  import cdec8_dbg_pkg::*;
#(
  parameter logic [7:0] FIRST_AD = 8'h00,
  parameter logic [7:0] LAST_AD  = RES_AD_LAST,
  parameter int         SETTLE   = 2,
  parameter logic [7:0] PARK_AD  = PARK_AD_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  cdec8_res_scanner_if.master   dbg,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            scan_cnt,
  input  logic [3:0]            rd_idx,
  output logic [7:0]            rd_dt
);

  localparam int         N         = win_size(FIRST_AD, LAST_AD);
  localparam logic [3:0] SETTLE_TC = 4'(SETTLE - 1);

  scan_state_t state;
  logic [7:0]  resad_q;
  logic [3:0]  idx;
  logic [3:0]  settle_cnt;

  assign dbg.resad = resad_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      resad_q    <= PARK_AD;
      idx        <= 4'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      scan_cnt   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          resad_q <= PARK_AD;
          if ((start | cont) & ~abort) begin
            state      <= ST_DRIVE;
            resad_q    <= FIRST_AD;
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            state   <= ST_IDLE;
            resad_q <= PARK_AD;
            busy    <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_TC) state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state   <= ST_IDLE;
            resad_q <= PARK_AD;
            busy    <= 1'b0;
          end else if (resad_q == LAST_AD) begin
            // Park during commit so every window address is held equally long
            state   <= ST_COMMIT;
            resad_q <= PARK_AD;
          end else begin
            state      <= ST_DRIVE;
            resad_q    <= resad_q + 8'd1;
            idx        <= idx + 4'd1;
            settle_cnt <= 4'd0;
          end
        end
        ST_COMMIT: begin
          done     <= 1'b1;
          scan_cnt <= scan_cnt + 8'd1;
          if (cont & ~abort) begin
            state      <= ST_DRIVE;
            resad_q    <= FIRST_AD;
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
          end else begin
            state   <= ST_IDLE;
            resad_q <= PARK_AD;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          resad_q <= PARK_AD;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  cdec8_snap_buf #(.DEPTH(N)) u_snap_buf (
    .clock  (clock),
    .reset  (reset),
    .wr_en  ((state == ST_SAMPLE) && !abort),
    .wr_idx (idx),
    .wr_dt  (dbg.resdt),
    .commit (state == ST_COMMIT),
    .rd_idx (rd_idx),
    .rd_dt  (rd_dt)
  );

endmodule
